// File: rtl/joy_db15_pkg.sv
// joy_db15_pkg: shared state type and parameter defaults for the DB15 joystick responder
package joy_db15_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;
  localparam int NBITS_DEF = 32;
  localparam int TIMEOUT_DEF = 1048576;
endpackage

// File: rtl/joy_db15_tx_sync_edge.sv
// sync_edge: 2-flop synchronizer with rise/fall detection, all flops reset high
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);
  logic meta_q, sync_q, prev_q;
  always_ff @(posedge clk)
    if (reset) {meta_q, sync_q, prev_q} <= '1;
    else {meta_q, sync_q, prev_q} <= {d_i, meta_q, sync_q};
  assign s_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: emulates the DB15 adapter's '165 shift register, serialising two players' buttons
module joy_db15_tx import joy_db15_pkg::*; #(
  parameter int NBITS = NBITS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  output logic        JOY_DATA,
  output logic        frame_done,
  output logic        active
);
  localparam int H = NBITS / 2;
  localparam int CW = $clog2(NBITS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  logic clk_s, clk_rise, clk_fall, load_s, load_rise, load_fall, shift_en;
  logic [NBITS-1:0] frame_w, sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic done_q, done_d, active_q, active_d;
  state_e state_q, state_d;
  sync_edge u_clk (.clk(clk), .reset(reset), .d_i(JOY_CLK), .s_o(clk_s), .rise_o(clk_rise), .fall_o(clk_fall));
  sync_edge u_load (.clk(clk), .reset(reset), .d_i(JOY_LOAD), .s_o(load_s), .rise_o(load_rise), .fall_o(load_fall));
  assign frame_w = ~{joy2[H-1:0], joy1[H-1:0]};
  // load dominates: any shift edge seen while load is low is dropped
  assign shift_en = (state_q == SHIFT) & load_s & clk_s & clk_rise & ~clk_fall;
  always_comb begin
    state_d = !load_s ? LOAD : load_rise ? SHIFT : state_q;
    sr_d = !load_s ? frame_w : shift_en ? {1'b1, sr_q[NBITS-1:1]} : sr_q;
    cnt_d = !load_s ? '0 : (shift_en && cnt_q != CW'(NBITS)) ? cnt_q + CW'(1) : cnt_q;
    done_d = shift_en && cnt_q == CW'(NBITS - 2);
    wd_d = load_fall ? '0 : (wd_q == WW'(TIMEOUT)) ? wd_q : wd_q + WW'(1);
    active_d = load_fall | (active_q & (wd_d != WW'(TIMEOUT)));
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      sr_q <= '1;
      cnt_q <= '0;
      done_q <= 1'b0;
      wd_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      wd_q <= wd_d;
      active_q <= active_d;
    end
  assign JOY_DATA = sr_q[0];
  assign frame_done = done_q;
  assign active = active_q;
endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx: directed master-side stimulus for joy_db15_tx with hand-computed frames
module tb_joy_db15_tx;
  logic clk, reset, JOY_CLK, JOY_LOAD, JOY_DATA, frame_done, active;
  logic [15:0] joy1, joy2;
  int total = 0, bad = 0, fd_cnt = 0, fd_at = -1, rises = 0;

  joy_db15_tx #(.NBITS(32), .TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .joy1(joy1), .joy2(joy2), .JOY_CLK(JOY_CLK),
    .JOY_LOAD(JOY_LOAD), .JOY_DATA(JOY_DATA), .frame_done(frame_done), .active(active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk)
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_at <= rises;
    end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_pulse();
    JOY_LOAD = 1'b0;
    cyc(6);
    JOY_LOAD = 1'b1;
    cyc(6);
  endtask

  task automatic clock_bit();
    JOY_CLK = 1'b1;
    rises++;
    cyc(5);
    JOY_CLK = 1'b0;
    cyc(5);
  endtask

  task automatic read_bits(input int n, output logic [63:0] b);
    b = '1;
    for (int i = 0; i < n; i++) begin
      b[i] = JOY_DATA;
      clock_bit();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    total++; if (JOY_DATA !== 1'b1) begin bad++; $display("FAIL reset_data got=%b exp=1", JOY_DATA); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_single();
    logic [63:0] b;
    int fd0;
    joy1 = 16'h0001; joy2 = 16'h0000;
    load_pulse();
    fd0 = fd_cnt; rises = 0;
    read_bits(40, b);
    total++; if (b[31:0] !== 32'hFFFFFFFE) begin bad++; $display("FAIL single_frame got=%h exp=fffffffe", b[31:0]); end
    total++; if (b[39:32] !== 8'hFF) begin bad++; $display("FAIL overclock_bits got=%h exp=ff", b[39:32]); end
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL single_done_count got=%0d exp=1", fd_cnt - fd0); end
    total++; if (fd_at !== 31) begin bad++; $display("FAIL single_done_pos got=%0d exp=31", fd_at); end
  endtask

  task automatic test_pattern();
    logic [63:0] b;
    int fd0;
    joy1 = 16'hA5A5; joy2 = 16'h3C3C;
    load_pulse();
    fd0 = fd_cnt; rises = 0;
    read_bits(32, b);
    total++; if (b[31:0] !== ~32'h3C3CA5A5) begin bad++; $display("FAIL pattern_frame got=%h exp=c3c35a5a", b[31:0]); end
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL pattern_done_count got=%0d exp=1", fd_cnt - fd0); end
    total++; if (fd_at !== 31) begin bad++; $display("FAIL pattern_done_pos got=%0d exp=31", fd_at); end
  endtask

  task automatic test_abort();
    logic [63:0] b;
    int fd0;
    joy1 = 16'hA5A5; joy2 = 16'h3C3C;
    load_pulse();
    fd0 = fd_cnt; rises = 0;
    read_bits(10, b);
    total++; if (b[9:0] !== 10'h25A) begin bad++; $display("FAIL abort_prefix got=%h exp=25a", b[9:0]); end
    joy1 = 16'h1234; joy2 = 16'hFEDC;
    load_pulse();
    total++; if (JOY_DATA !== 1'b1) begin bad++; $display("FAIL abort_reload_bit0 got=%b exp=1", JOY_DATA); end
    total++; if (fd_cnt - fd0 !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", fd_cnt - fd0); end
    rises = 0;
    read_bits(32, b);
    total++; if (b[31:0] !== 32'h0123EDCB) begin bad++; $display("FAIL abort_next_frame got=%h exp=0123edcb", b[31:0]); end
    total++; if (fd_cnt - fd0 !== 1 || fd_at !== 31) begin bad++; $display("FAIL abort_next_done got=%0d@%0d exp=1@31", fd_cnt - fd0, fd_at); end
  endtask

  task automatic test_load_low();
    logic [63:0] b;
    int fd0;
    joy1 = 16'h0001; joy2 = 16'h0000;
    JOY_LOAD = 1'b0;
    cyc(6);
    for (int i = 0; i < 3; i++) begin
      clock_bit();
      total++; if (JOY_DATA !== 1'b0) begin bad++; $display("FAIL loadlow_hold%0d got=%b exp=0", i, JOY_DATA); end
    end
    joy1 = 16'h0002;
    cyc(4);
    total++; if (JOY_DATA !== 1'b1) begin bad++; $display("FAIL loadlow_transparent got=%b exp=1", JOY_DATA); end
    JOY_LOAD = 1'b1;
    cyc(6);
    fd0 = fd_cnt; rises = 0;
    read_bits(32, b);
    total++; if (b[31:0] !== 32'hFFFFFFFD) begin bad++; $display("FAIL loadlow_frame got=%h exp=fffffffd", b[31:0]); end
    total++; if (fd_cnt - fd0 !== 1 || fd_at !== 31) begin bad++; $display("FAIL loadlow_done got=%0d@%0d exp=1@31", fd_cnt - fd0, fd_at); end
  endtask

  task automatic test_latency();
    joy1 = 16'h0001; joy2 = 16'h0000;
    load_pulse();
    JOY_CLK = 1'b1;
    cyc(2);
    total++; if (JOY_DATA !== 1'b0) begin bad++; $display("FAIL latency_early got=%b exp=0", JOY_DATA); end
    cyc(1);
    total++; if (JOY_DATA !== 1'b1) begin bad++; $display("FAIL latency_3cyc got=%b exp=1", JOY_DATA); end
    cyc(3);
    JOY_CLK = 1'b0;
    cyc(5);
  endtask

  task automatic test_timeout();
    int first, hi;
    cyc(120);
    total++; if (active !== 1'b0) begin bad++; $display("FAIL timeout_idle got=%b exp=0", active); end
    first = -1; hi = 0;
    JOY_LOAD = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      cyc(1);
      if (i == 6) JOY_LOAD = 1'b1;
      if (active === 1'b1) begin
        hi++;
        if (first < 0) first = i;
      end
    end
    total++; if (first !== 3) begin bad++; $display("FAIL timeout_rise got=%0d exp=3", first); end
    total++; if (hi !== 100) begin bad++; $display("FAIL timeout_width got=%0d exp=100", hi); end
    JOY_LOAD = 1'b0;
    cyc(2);
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reload_early got=%b exp=0", active); end
    cyc(1);
    total++; if (active !== 1'b1) begin bad++; $display("FAIL reload_active got=%b exp=1", active); end
    cyc(3);
    JOY_LOAD = 1'b1;
    cyc(6);
  endtask

  task automatic test_reset_mid();
    logic [63:0] b;
    joy1 = 16'hFFFF; joy2 = 16'h0000;
    load_pulse();
    read_bits(3, b);
    total++; if (JOY_DATA !== 1'b0 || active !== 1'b1) begin bad++; $display("FAIL midframe_pre got=%b/%b exp=0/1", JOY_DATA, active); end
    reset = 1'b1;
    cyc(1);
    total++; if (JOY_DATA !== 1'b1 || active !== 1'b0) begin bad++; $display("FAIL midframe_reset got=%b/%b exp=1/0", JOY_DATA, active); end
    reset = 1'b0;
    cyc(4);
    load_pulse();
    read_bits(32, b);
    total++; if (b[31:0] !== 32'hFFFF0000) begin bad++; $display("FAIL post_reset_frame got=%h exp=ffff0000", b[31:0]); end
  endtask

  initial begin
    reset = 1'b1; JOY_CLK = 1'b0; JOY_LOAD = 1'b1; joy1 = '0; joy2 = '0;
    cyc(3);
    test_reset();
    test_single();
    test_pattern();
    test_abort();
    test_load_low();
    test_latency();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/joy_db15_tx.md
# joy_db15_tx

Responder side of the DB15 serial joystick link: it emulates the adapter's parallel-in/serial-out shift register. A master drives `JOY_LOAD` and `JOY_CLK`; this block presents two players' button state on `JOY_DATA` one bit per clock. It sits on the user-port boundary when the core exports local joystick state to a second board, and it serves as the bench model for the existing DB15 receiver.

## Interface
Parameters:
- `NBITS`, 32: frame length in bits. Must be even, with 2 ≤ `NBITS` ≤ 32. Each player contributes `NBITS/2` bits.
- `TIMEOUT`, 1048576: number of `clk` cycles without a load before `active` drops.

Ports:
- `clk`  in  1  system clock, 40–50 MHz. One clock domain.
- `reset`  in  1  synchronous, active-high.
- `joy1`  in  16  player 1 state, active-high, bit order FEDCBAUDLR (bit 0 = R). Only bits `[NBITS/2-1:0]` are used.
- `joy2`  in  16  player 2 state, same format as `joy1`.
- `JOY_CLK`  in  1  shift clock from the master. Asynchronous to `clk`.
- `JOY_LOAD`  in  1  parallel load, active-low. Asynchronous to `clk`.
- `JOY_DATA`  out  1  serial data, active-low (pressed = 0). Registered.
- `frame_done`  out  1  one-cycle pulse when the last frame bit is shifted out.
- `active`  out  1  high while the master keeps issuing loads within `TIMEOUT`.

## Operation
- Frame word `W = ~{joy2[NBITS/2-1:0], joy1[NBITS/2-1:0]}`. Transmission is LSB first, so the first bit on the wire is `~joy1[0]` (R).
- Shift register `sr[NBITS-1:0]`. `JOY_DATA = sr[0]`.
- `JOY_CLK` and `JOY_LOAD` each pass through a 2-flop synchronizer followed by an edge detector, giving `clk_s`, `clk_rise`, `load_s`, `load_fall`, `load_rise`.
- States:
  - **IDLE** (after reset).
  - **LOAD**: entered while `load_s == 0`. `sr <= W` every cycle (transparent, like a '165). Bit counter `cnt <= 0`.
  - **SHIFT**: entered on `load_rise`. On each `clk_rise`: `sr <= {1'b1, sr[NBITS-1:1]}`, `cnt <= cnt + 1`.
- `frame_done` pulses on the `clk_rise` that makes `cnt == NBITS-1`. That shift presents the last bit, `~joy2[NBITS/2-1]`.
- Over-clocking: further `clk_rise` events shift in 1s, so `JOY_DATA = 1`. `cnt` saturates at `NBITS`. No second `frame_done` is issued.
- Load has priority:
  - `clk_rise` while `load_s == 0` is ignored.
  - `load_fall` in the middle of a frame aborts it, reloads `W`, and issues no `frame_done`.
- Inputs `joy1`/`joy2` are sampled every cycle in LOAD. The frame carries the values from the last LOAD cycle before `load_rise`.
- Watchdog:
  - `wd` counts `clk` cycles and clears on `load_fall`.
  - `active <= 1` on `load_fall`.
  - `active <= 0` when `wd` reaches `TIMEOUT`; `wd` saturates there.
  - Counter width is `$clog2(TIMEOUT+1)`.
- Reset values (cycle after `reset`): state IDLE, `sr` all 1s, `JOY_DATA = 1`, `cnt = 0`, `frame_done = 0`, `active = 0`, `wd = 0`, synchronizer flops = 1.

## Timing
- Pin-to-effect latency is 3 `clk` cycles: 2 synchronizer stages plus 1 register update. A `JOY_CLK` rising edge at the pin changes `JOY_DATA` exactly 3 cycles later (±1 for metastability resolution).
- Master constraints:
  - `JOY_CLK` high and low phases ≥ 4 `clk` cycles each.
  - `JOY_LOAD` low ≥ 4 cycles.
  - ≥ 4 cycles between `JOY_LOAD` rising and the first `JOY_CLK` rising.
- The master samples `JOY_DATA` before its next rising `JOY_CLK` edge.
- `frame_done` is asserted in the same cycle that `sr` presents the last bit.
- `reset` overrides everything in the same cycle, including in the middle of a frame.

## Structure
- Package `joy_db15_pkg`:
  - state enum `{IDLE, LOAD, SHIFT}`
  - default `NBITS`
  - default `TIMEOUT`
- Sub-module `sync_edge`: 2-flop synchronizer plus rise/fall detector, reset value 1. Instantiated twice, once for `JOY_CLK` and once for `JOY_LOAD`.
- Top module: FSM, shift register, bit counter, watchdog.

## Test plan
- `joy1 = 16'h0001`, `joy2 = 0`, load pulse, then 32 clocks → `JOY_DATA` sequence 0 then thirty-one 1s; `frame_done` pulses once, coinciding with bit 31.
- `joy1 = 16'hA5A5`, `joy2 = 16'h3C3C`, full frame → the 32 collected bits equal `~32'h3C3CA5A5`, LSB first.
- 40 clocks after a load → bits 32–39 read 1; `frame_done` count = 1.
- Load asserted at bit 10 of a frame → `sr` reloads, no `frame_done`, the next frame is correct from bit 0.
- `JOY_CLK` pulses while `JOY_LOAD` is low → `JOY_DATA` stays `~joy1[0]` and `cnt` stays 0. Check `JOY_DATA` changes exactly 3 cycles after a `JOY_CLK` edge.
- With `TIMEOUT = 100`: load, then idle 100 cycles → `active` = 1 until the timeout cycle, then 0. The next load → `active = 1` after 3 cycles. Assert `reset` mid-frame → `JOY_DATA = 1`, `active = 0` on the next cycle.
